// File: rtl/gen3_lfsr_keystream.sv
// -----------------------------------------------------------------------------
// gen3_lfsr_keystream
//
// Per-lane 128b/130b scrambler keystream generator. The LFSR is a 23-bit
// Galois LFSR with polynomial x^23+x^21+x^16+x^8+x^5+x^2+1. Each cycle it
// produces up to four keystream bytes, one per symbol of a 4-symbol beat. The
// bytes are registered and consumed one cycle later by the data scrambler.
//
// Bytes whose advance bit is clear (SKP symbols) take no keystream. Those
// bytes output 8'h00, and the running state passes through them unchanged.
// Enabled bytes therefore see a contiguous keystream, even when SKP bytes are
// interleaved.
//
// Parameters
//   LANE_NUM              physical lane number; the seed is chosen by LANE_NUM%8
//
// Ports
//   clk_i                 clock
//   rst_n_i               asynchronous active-low reset (loads the lane seed)
//   valid_i               a 4-symbol beat is present this cycle
//   advance_en_i[3:0]     per-byte keystream consume (1 = take 8 bits)
//   seed_load_i           reseed after this cycle's beat (EIEOS end)
//   lfsr1..4_scramble_value  registered keystream for bytes 0..3
//   valid_o               keystream outputs valid (valid_i delayed 1 cycle)
//   lfsr_state_o          current LFSR state (used by the next beat)
// -----------------------------------------------------------------------------
module gen3_lfsr_keystream #(
  parameter int LANE_NUM = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        valid_i,
  input  logic [3:0]  advance_en_i,
  input  logic        seed_load_i,
  output logic [7:0]  lfsr1_scramble_value,
  output logic [7:0]  lfsr2_scramble_value,
  output logic [7:0]  lfsr3_scramble_value,
  output logic [7:0]  lfsr4_scramble_value,
  output logic        valid_o,
  output logic [22:0] lfsr_state_o
);

  // ---------------------------------------------------------------------------
  // Lane seed table
  // ---------------------------------------------------------------------------
  function automatic logic [22:0] lane_seed(input int lane);
    logic [22:0] seed;
    case (lane % 8)
      0:       seed = 23'h1DBFBC;
      1:       seed = 23'h0607BB;
      2:       seed = 23'h1EC760;
      3:       seed = 23'h18C0DB;
      4:       seed = 23'h010F12;
      5:       seed = 23'h19CFC9;
      6:       seed = 23'h0277CE;
      default: seed = 23'h1BB807;
    endcase
    return seed;
  endfunction

  localparam logic [22:0] SEED = lane_seed(LANE_NUM);

  // ---------------------------------------------------------------------------
  // Single LFSR bit step (Galois form). The MSB is fed back into bit 0 and
  // XORed into each tap position as the register shifts up.
  // ---------------------------------------------------------------------------
  function automatic logic [22:0] bit_step(input logic [22:0] s);
    logic [22:0] n;
    n[0] = s[22];
    for (int i = 1; i < 23; i++) begin
      if (i == 2 || i == 5 || i == 8 || i == 16 || i == 21) begin
        n[i] = s[i-1] ^ s[22];
      end else begin
        n[i] = s[i-1];
      end
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Byte step: eight bit steps. The first output bit lands in bit 0 of the
  // keystream byte (LSB first). Returns {keystream_byte, next_state}.
  // ---------------------------------------------------------------------------
  function automatic logic [30:0] byte_step(input logic [22:0] s);
    logic [22:0] st;
    logic [7:0]  k;
    st = s;
    k  = 8'h00;
    for (int b = 0; b < 8; b++) begin
      k[b] = st[22];
      st   = bit_step(st);
    end
    return {k, st};
  endfunction

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  logic [22:0]      r_state;
  logic [3:0][7:0]  r_key;
  logic             r_valid;

  // ---------------------------------------------------------------------------
  // Combinational keystream chain: four byte steps in series. A disabled byte
  // bypasses its step, so the next enabled byte continues from the same point.
  // ---------------------------------------------------------------------------
  logic [3:0][7:0]  w_key;
  logic [22:0]      w_next_state;

  always_comb begin
    logic [22:0] run;
    logic [30:0] step;
    run   = r_state;
    step  = '0;
    w_key = '0;
    for (int n = 0; n < 4; n++) begin
      step = byte_step(run);
      if (advance_en_i[n]) begin
        w_key[n] = step[30:23];
        run      = step[22:0];
      end else begin
        w_key[n] = 8'h00;
      end
    end
    w_next_state = run;
  end

  // ---------------------------------------------------------------------------
  // Sequential update. The seed load wins over the beat's advance. The beat in
  // the same cycle is still output, and it uses the pre-load state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= SEED;
      r_key   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= valid_i;
      r_key   <= valid_i ? w_key : '0;
      if (seed_load_i) begin
        r_state <= SEED;
      end else if (valid_i) begin
        r_state <= w_next_state;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign lfsr1_scramble_value = r_key[0];
  assign lfsr2_scramble_value = r_key[1];
  assign lfsr3_scramble_value = r_key[2];
  assign lfsr4_scramble_value = r_key[3];
  assign valid_o              = r_valid;
  assign lfsr_state_o         = r_state;

endmodule

// File: tb/tb_gen3_lfsr_keystream.sv
// -----------------------------------------------------------------------------
// tb_gen3_lfsr_keystream
//
// Directed bench for gen3_lfsr_keystream. A lane-0 instance is exercised with
// streaming, SKP gaps, reseed, idle and mid-stream reset. Expected keystream
// comes from a bit-serial LFSR reference model. Lanes 1..7 are instantiated
// only so that their reset seeds can be checked.
// -----------------------------------------------------------------------------
module tb_gen3_lfsr_keystream;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        valid_i;
  logic [3:0]  advance_en_i;
  logic        seed_load_i;
  logic [7:0]  lfsr1_scramble_value;
  logic [7:0]  lfsr2_scramble_value;
  logic [7:0]  lfsr3_scramble_value;
  logic [7:0]  lfsr4_scramble_value;
  logic        valid_o;
  logic [22:0] lfsr_state_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [22:0] seeds [8];
  logic [22:0] m_state;

  always #5 clk_i = ~clk_i;

  gen3_lfsr_keystream #(.LANE_NUM(0)) dut (
    .clk_i                (clk_i),
    .rst_n_i              (rst_n_i),
    .valid_i              (valid_i),
    .advance_en_i         (advance_en_i),
    .seed_load_i          (seed_load_i),
    .lfsr1_scramble_value (lfsr1_scramble_value),
    .lfsr2_scramble_value (lfsr2_scramble_value),
    .lfsr3_scramble_value (lfsr3_scramble_value),
    .lfsr4_scramble_value (lfsr4_scramble_value),
    .valid_o              (valid_o),
    .lfsr_state_o         (lfsr_state_o)
  );

  // Lanes 1..7: reset-seed checks only; inputs held idle.
  logic [22:0] lane_state [8];
  logic [7:0]  lane_k1 [8];
  logic [7:0]  lane_k2 [8];
  logic [7:0]  lane_k3 [8];
  logic [7:0]  lane_k4 [8];
  logic        lane_v  [8];

  for (genvar gi = 1; gi < 8; gi++) begin : g_lane
    gen3_lfsr_keystream #(.LANE_NUM(gi)) u_lane (
      .clk_i                (clk_i),
      .rst_n_i              (rst_n_i),
      .valid_i              (1'b0),
      .advance_en_i         (4'h0),
      .seed_load_i          (1'b0),
      .lfsr1_scramble_value (lane_k1[gi]),
      .lfsr2_scramble_value (lane_k2[gi]),
      .lfsr3_scramble_value (lane_k3[gi]),
      .lfsr4_scramble_value (lane_k4[gi]),
      .valid_o              (lane_v[gi]),
      .lfsr_state_o         (lane_state[gi])
    );
  end

  // Bit-serial reference: output MSB, shift left, fold the MSB into the taps.
  function automatic logic model_bit();
    logic       b;
    logic [22:0] sh;
    b  = m_state[22];
    sh = {m_state[21:0], m_state[22]};
    if (b) sh = sh ^ 23'h210124;
    m_state = sh;
    return b;
  endfunction

  function automatic logic [7:0] model_byte();
    logic [7:0] k;
    k = 8'h00;
    for (int i = 0; i < 8; i++) k[i] = model_bit();
    return k;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " valid_o"}, {31'd0, valid_o}, 32'd0);
    chk({tag, " keys"}, {lfsr4_scramble_value, lfsr3_scramble_value,
                         lfsr2_scramble_value, lfsr1_scramble_value}, 32'd0);
  endtask

  // One directed beat: drive on the falling edge, check just after the rising edge.
  task automatic beat(input string tag, input logic v, input logic [3:0] adv, input logic sl);
    logic [7:0] exp_b [4];
    @(negedge clk_i);
    valid_i      = v;
    advance_en_i = adv;
    seed_load_i  = sl;
    for (int n = 0; n < 4; n++) exp_b[n] = (v && adv[n]) ? model_byte() : 8'h00;
    if (sl) m_state = seeds[0];
    @(posedge clk_i);
    #1;
    chk({tag, " valid_o"}, {31'd0, valid_o}, {31'd0, v});
    chk({tag, " keys"}, {lfsr4_scramble_value, lfsr3_scramble_value,
                         lfsr2_scramble_value, lfsr1_scramble_value},
        {exp_b[3], exp_b[2], exp_b[1], exp_b[0]});
    chk({tag, " state"}, {9'd0, lfsr_state_o}, {9'd0, m_state});
  endtask

  initial begin
    seeds = '{23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
              23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807};
    rst_n_i      = 1'b0;
    valid_i      = 1'b0;
    advance_en_i = 4'h0;
    seed_load_i  = 1'b0;
    m_state      = seeds[0];

    // Reset: seeds on all lanes, outputs cleared.
    #12;
    chk("rst lane0 state", {9'd0, lfsr_state_o}, {9'd0, seeds[0]});
    chk_idle_outputs("rst lane0");
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("rst lane%0d state", i), {9'd0, lane_state[i]}, {9'd0, seeds[i]});
      chk($sformatf("rst lane%0d out", i),
          {lane_k4[i], lane_k3[i], lane_k2[i], lane_k1[i]} | {31'd0, lane_v[i]}, 32'd0);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Streaming: 64 full beats.
    for (int i = 0; i < 64; i++) beat($sformatf("stream%0d", i), 1'b1, 4'hF, 1'b0);

    // SKP gaps interleaved with full beats.
    beat("skp 0110", 1'b1, 4'b0110, 1'b0);
    beat("skp full a", 1'b1, 4'hF, 1'b0);
    beat("skp 1000", 1'b1, 4'b1000, 1'b0);
    beat("skp 1010", 1'b1, 4'b1010, 1'b0);
    beat("skp 0000", 1'b1, 4'b0000, 1'b0);
    beat("skp full b", 1'b1, 4'hF, 1'b0);

    // Reseed: the beat uses the old state, then the state returns to the seed.
    beat("reseed beat", 1'b1, 4'hF, 1'b1);
    chk("reseed state is seed", {9'd0, lfsr_state_o}, {9'd0, seeds[0]});
    beat("after reseed", 1'b1, 4'hF, 1'b0);
    beat("b2b reseed 1", 1'b1, 4'hF, 1'b1);
    beat("b2b reseed 2", 1'b1, 4'hF, 1'b1);
    beat("reseed idle", 1'b0, 4'hF, 1'b1);
    beat("post b2b", 1'b1, 4'hF, 1'b0);

    // Idle hold with random advance enables.
    for (int i = 0; i < 10; i++)
      beat($sformatf("idle%0d", i), 1'b0, 4'($urandom_range(0, 15)), 1'b0);

    // Mid-stream reset: outputs drop without a clock edge.
    beat("pre reset a", 1'b1, 4'hF, 1'b0);
    beat("pre reset b", 1'b1, 4'hF, 1'b0);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk_idle_outputs("async reset");
    chk("async reset state", {9'd0, lfsr_state_o}, {9'd0, seeds[0]});
    m_state = seeds[0];
    @(negedge clk_i);
    valid_i = 1'b0;
    rst_n_i = 1'b1;
    beat("post reset 0", 1'b1, 4'hF, 1'b0);
    beat("post reset 1", 1'b1, 4'b0101, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
